// File: rtl/tic_stopwatch_pkg.sv
// ============================================================================
// tic_stopwatch_pkg
// Shared types and constants for the tic_stopwatch block: FSM state
// encoding, BCD digit type and the largest legal BCD digit value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tic_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage : tic_stopwatch_pkg

`default_nettype wire

// File: rtl/bcd_digit_cell.sv
// ============================================================================
// bcd_digit_cell
// One decade of the stopwatch counter. Increments on inc, wraps 9 -> 0 and
// raises carry_out in the same cycle so the next decade steps with it.
//   clk       : in  system clock
//   rst       : in  asynchronous active-low reset
//   clr       : in  synchronous zero (highest priority after reset)
//   inc       : in  carry in / increment request
//   value     : out registered BCD digit (0..9)
//   carry_out : out inc && value == 9 (combinational, feeds next cell)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_cell
  import tic_stopwatch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic carry_out
);

  bcd_t value_q;
  bcd_t value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == BCD_MAX) ? bcd_t'(0) : value_q + bcd_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign carry_out = inc && (value_q == BCD_MAX);

endmodule : bcd_digit_cell

`default_nettype wire

// File: rtl/tic_stopwatch.sv
// ============================================================================
// tic_stopwatch
// Counts tic strobes into a NUM_DIGITS-digit BCD stopwatch value under
// start_stop / clear command pulses. All outputs are registered.
//   clk        : in  system clock
//   rst        : in  asynchronous active-low reset
//   tic        : in  one count unit per cycle high
//   start_stop : in  toggles RUN/PAUSE (IDLE -> RUN)
//   clear      : in  zero count and overflow, go IDLE; beats everything
//   digits     : out BCD value, digit 0 in [3:0]
//   running    : out high while in RUN
//   overflow   : out sticky, set on wrap from all-9s to zero
// Optional (macro TIC_STOPWATCH_LAP_EN):
//   lap        : in  capture current digits while in RUN
//   lap_digits : out captured lap value
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tic_stopwatch
  import tic_stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tic,
  input  logic                    start_stop,
  input  logic                    clear,
`ifdef TIC_STOPWATCH_LAP_EN
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] lap_digits,
`endif
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    overflow
);

  sw_state_t state_q, state_d;
  logic      running_q, running_d;
  logic      overflow_q, overflow_d;

  // carry[0] is the increment request into digit 0; carry[NUM_DIGITS] is the
  // all-9s wrap indication.
  logic [NUM_DIGITS:0] carry;

  // A tic in the clear cycle must not count, so clear gates the chain input.
  assign carry[0] = (state_q == RUN) && tic && !clear;

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk       (clk),
        .rst       (rst),
        .clr       (clear),
        .inc       (carry[i]),
        .value     (digits[4*i +: 4]),
        .carry_out (carry[i+1])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
    running_d  = (state_d == RUN);
    overflow_d = clear ? 1'b0 : (overflow_q | carry[NUM_DIGITS]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef TIC_STOPWATCH_LAP_EN
  logic [4*NUM_DIGITS-1:0] lap_q, lap_d;

  // digits is the register output, so a same-cycle tic yields the
  // pre-increment value naturally.
  always_comb begin
    lap_d = lap_q;
    if (clear) begin
      lap_d = '0;
    end else if (lap && (state_q == RUN)) begin
      lap_d = digits;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign lap_digits = lap_q;
`endif

endmodule : tic_stopwatch

`default_nettype wire

// File: tb/tb_tic_stopwatch.sv
// ============================================================================
// tb_tic_stopwatch
// Self-checking bench for tic_stopwatch: a count-level model is compared
// against the DUT every cycle, plus directed literal checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tic_stopwatch;

  localparam int ND   = 4;
  localparam int MAXC = 10 ** ND;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tic = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic [4*ND-1:0] digits;
  logic running;
  logic overflow;
`ifdef TIC_STOPWATCH_LAP_EN
  logic [4*ND-1:0] lap_digits;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tic_stopwatch #(.NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst        (rst),
    .tic        (tic),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef TIC_STOPWATCH_LAP_EN
    .lap        (lap),
    .lap_digits (lap_digits),
`endif
    .digits     (digits),
    .running    (running),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- model: plain integer count + run flag ----------------
  int m_cnt = 0;
  bit m_run = 1'b0;
  bit m_ovf = 1'b0;
  int m_lap = 0;

  function automatic logic [4*ND-1:0] to_bcd(input int x);
    logic [4*ND-1:0] r;
    int v;
    v = x;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_run = 1'b0; m_ovf = 1'b0; m_lap = 0;
    end else if (clear) begin
      m_cnt = 0; m_run = 1'b0; m_ovf = 1'b0; m_lap = 0;
    end else begin
      if (m_run && lap) m_lap = m_cnt;
      if (m_run && tic) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == MAXC) begin
          m_cnt = 0;
          m_ovf = 1'b1;
        end
      end
      if (start_stop) m_run = !m_run;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(posedge clk) begin
    #1;
    check("model_digits", 32'(digits), 32'(to_bcd(m_cnt)));
    check("model_running", 32'(running), 32'(m_run));
    check("model_overflow", 32'(overflow), 32'(m_ovf));
`ifdef TIC_STOPWATCH_LAP_EN
    check("model_lap", 32'(lap_digits), 32'(to_bcd(m_lap)));
`endif
  end

  // ---------------- stimulus ----------------
  // Holds the given inputs across one rising edge, returns at the next negedge.
  task automatic step(input logic t, input logic ss, input logic clr, input logic lp);
    tic = t; start_stop = ss; clear = clr; lap = lp;
    @(negedge clk);
    tic = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic tics(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // tics in IDLE are ignored
    tics(5);
    check("idle_tics_digits", 32'(digits), 32'h0);
    check("idle_tics_running", 32'(running), 32'h0);

    // start, 12 tics spaced 3 cycles; check right after the last tic
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (i != 11) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    check("run12_digits", 32'(digits), 32'h0012);
    check("run12_running", 32'(running), 32'h1);

    // pause, tics ignored, resume, one tic
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tics(4);
    check("pause_hold", 32'(digits), 32'h0012);
    check("pause_running", 32'(running), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tics(1);
    check("resume_digits", 32'(digits), 32'h0013);

    // preload to 9998, then wrap
    tics(9998 - 13);
    check("preload", 32'(digits), 32'h9998);
    tics(1);
    check("all_nines", 32'(digits), 32'h9999);
    check("no_ovf_yet", 32'(overflow), 32'h0);
    tics(1);
    check("wrap_digits", 32'(digits), 32'h0000);
    check("wrap_overflow", 32'(overflow), 32'h1);
    tics(2);
    check("ovf_sticky", 32'(overflow), 32'h1);
    check("count_after_wrap", 32'(digits), 32'h0002);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_digits", 32'(digits), 32'h0);
    check("clear_overflow", 32'(overflow), 32'h0);
    check("clear_running", 32'(running), 32'h0);

    // clear + tic while running at 41
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tics(41);
    check("at_41", 32'(digits), 32'h0041);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("clr_tic_digits", 32'(digits), 32'h0);
    check("clr_tic_running", 32'(running), 32'h0);
    tics(2);
    check("idle_after_clr", 32'(digits), 32'h0);

    // clear + start_stop: clear wins, stays idle
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_ss_running", 32'(running), 32'h0);

    // start_stop + tic in IDLE: tic not counted
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ss_tic_idle_digits", 32'(digits), 32'h0);
    check("ss_tic_idle_running", 32'(running), 32'h1);
    tics(3);
    // start_stop + tic in RUN: tic counted, then pause
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ss_tic_run_digits", 32'(digits), 32'h0004);
    check("ss_tic_run_running", 32'(running), 32'h0);
    // start_stop + tic in PAUSE: unchanged count, running
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("ss_tic_pause_digits", 32'(digits), 32'h0004);
    check("ss_tic_pause_running", 32'(running), 32'h1);

    // start_stop held high toggles each cycle, with tic held too
    tic = 1'b1; start_stop = 1'b1;
    repeat (3) @(negedge clk);
    tic = 1'b0; start_stop = 1'b0;
    // RUN(count 5)->PAUSE, PAUSE->RUN, RUN(count 6)->PAUSE
    check("held_ss_digits", 32'(digits), 32'h0006);
    check("held_ss_running", 32'(running), 32'h0);

    // resume and count to 307, then async reset off the edge
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tics(307 - 6);
    check("at_307", 32'(digits), 32'h0307);
    tic = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_rst_digits", 32'(digits), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    @(negedge clk);
    tic = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_digits", 32'(digits), 32'h0);

`ifdef TIC_STOPWATCH_LAP_EN
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tics(25);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("lap_value", 32'(lap_digits), 32'h0025);
    check("lap_digits_run", 32'(digits), 32'h0026);
    tics(3);
    check("lap_hold", 32'(lap_digits), 32'h0025);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_paused_ignored", 32'(lap_digits), 32'h0025);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("lap_clear", 32'(lap_digits), 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tic_stopwatch

`default_nettype wire

// File: doc/tic_stopwatch.md
Name: tic_stopwatch

Overview:
- Consumes the one-cycle periodic `tic` strobe from the team's tick generator and counts tics into a multi-digit BCD stopwatch value.
- Controlled by single-cycle `start_stop` and `clear` command pulses.
- Feeds the display path, e.g. a seven-segment scan driver, with registered BCD digits plus run and overflow status.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; maximum count is 10^NUM_DIGITS - 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tic  input  1  one-cycle strobe from the tick generator; one count unit per pulse.
- start_stop  input  1  one-cycle command pulse; toggles between running and paused.
- clear  input  1  one-cycle command pulse; zeroes count, returns to idle.
- digits  output  4*NUM_DIGITS  BCD value; digit 0 (least significant) in bits [3:0].
- running  output  1  high while state is RUN.
- overflow  output  1  sticky; set on wrap from all-9s to zero.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, digits all 0, running 0, overflow 0.
- All outputs are registered. A tic accepted in cycle N is visible on digits in cycle N+1.
- FSM states: IDLE, RUN, PAUSE. Transitions:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - Any state + clear -> IDLE, digits zeroed, overflow cleared.
- Counting: only in RUN. Each tic increments digit 0. A digit at 9 receiving a carry becomes 0 and carries into the next digit.
  - Digits never hold values 10-15.
- Wrap: all digits at 9 plus tic -> all digits 0, overflow set to 1. Counting continues; overflow stays 1 until clear or reset.
- running equals (state == RUN), registered with the state.
- Simultaneous events:
  - clear plus anything: clear wins. start_stop is ignored that cycle; a tic that cycle is not counted.
  - start_stop plus tic in RUN: tic is counted, then state goes PAUSE.
  - start_stop plus tic in IDLE or PAUSE: tic not counted; state goes RUN and counting starts with the next tic.
- tic in IDLE or PAUSE: ignored, digits hold.
- Inputs are synchronous to clk. No internal pulse shaping: a level held high is treated as a pulse every cycle.
  - start_stop held high toggles RUN/PAUSE each cycle.
- Reset asserted mid-count: immediate return to reset values. No count is retained.

Optional Feature:
- Macro: TIC_STOPWATCH_LAP_EN.
- Defined:
  - Adds input `lap` (1-bit pulse) and output `lap_digits` (4*NUM_DIGITS).
  - A lap pulse in RUN captures the current digits register, the pre-increment value if a tic arrives the same cycle. lap_digits shows it the next cycle.
  - lap is ignored in IDLE and PAUSE.
  - clear and reset zero lap_digits. clear plus lap same cycle: clear wins.
- Not defined: ports absent, no lap register; behaviour otherwise identical.

Decomposition:
- Package `tic_stopwatch_pkg`:
  - enum typedef `sw_state_t` {IDLE, RUN, PAUSE}.
  - typedef `bcd_t` as logic [3:0].
  - constant `BCD_MAX` = 4'd9.
- Sub-module `bcd_digit_cell`:
  - Inputs: clk, rst, clr, inc (carry in).
  - Outputs: 4-bit value, carry_out = inc && value == 9.
  - Instantiated NUM_DIGITS times in a generate chain. The FSM lives in the top.

Test Plan:
- Reset then 5 tics with no start_stop -> digits 0x0000, running 0.
- start_stop, then 12 tics, each tic spaced 3 cycles -> digits 0x0012 one cycle after the last tic, running 1.
- From 0x0012: start_stop to pause, 4 tics, start_stop, 1 tic -> digits hold 0x0012 through pause, then 0x0013.
- Preload to 0x9998 by ticking while running, then 2 tics -> 0x9999, then 0x0000 with overflow 1. Then clear -> 0x0000, overflow 0, running 0.
- clear and tic in the same cycle while running at 0x0041 -> 0x0000, state IDLE. start_stop and tic together in PAUSE -> count unchanged, running 1 next cycle.
- Drive rst low asynchronously mid-run at 0x0307, off the clock edge -> digits 0x0000, running 0 before the next clk edge. With TIC_STOPWATCH_LAP_EN defined: lap at 0x0025 -> lap_digits 0x0025 next cycle while digits keep counting.
